ysyx_l1i_fetch: RTL
===================

# ysyx_l1i_fetch

Parametrised instruction-fetch unit with a set-associative L1 instruction cache and burst line refill. It is the next-generation fetch stage and sits between the PC/branch logic (upstream valid/ready) and the decoder (downstream valid/ready). Misses go to the bus arbiter as one burst read per cache line. A flush input invalidates the whole cache for `fence.i`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, instruction/bus word width
- `LINE_WORDS`, 4, words per line; power of two, 1..16
- `SETS`, 16, sets; power of two, ≥2
- `WAYS`, 2, associativity; 1 or 2

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `prev_valid`  in  1  upstream fetch request valid
- `ready_o`  out  1  block can accept a request
- `pc`  in  ADDR_W  fetch address; bits [1:0] ignored
- `flush_i`  in  1  invalidate all lines (one-cycle pulse)
- `valid_o`  out  1  instruction valid to decoder
- `next_ready`  in  1  decoder accepts instruction
- `inst_o`  out  DATA_W  fetched instruction
- `pc_o`  out  ADDR_W  address of `inst_o`
- `ifu_araddr_o`  out  ADDR_W  burst start address
- `ifu_arlen_o`  out  8  beats minus one
- `ifu_arvalid_o`  out  1  read request valid
- `ifu_arready`  in  1  read request accepted
- `ifu_rdata`  in  DATA_W  read beat data
- `ifu_rvalid`  in  1  read beat valid
- `ifu_rlast`  in  1  final beat marker

## Operation
- Address split: offset = low log2(LINE_WORDS·4) bits, word select = offset[..:2], index = next log2(SETS) bits, tag = remaining bits.
- States: IDLE, LOOKUP, REQ, FILL, OUT.
- IDLE: `ready_o`=1. Handshake `prev_valid & ready_o` latches `pc` into the request register and moves to LOOKUP.
- LOOKUP: compare the tags of all ways in the set.
  - Hit: select the word, load `inst_o`/`pc_o`, update LRU, go to OUT.
  - Miss: choose a victim (invalid way0 first, then invalid way1, else the LRU way), go to REQ.
- REQ: `ifu_arvalid_o`=1, `ifu_araddr_o` = line-aligned request address, `ifu_arlen_o` = LINE_WORDS-1. Hold all three stable until `ifu_arready`, then go to FILL.
- FILL: on each `ifu_rvalid`, write the beat to the victim line at the beat counter position and increment the counter.
  - The beat whose index equals the request word also loads `inst_o`.
  - After beat LINE_WORDS-1: set tag and valid, set LRU to point at the other way, go to OUT.
  - `ifu_rlast` is not used for control.
- OUT: `valid_o`=1. On `next_ready`: if `prev_valid`, accept the new `pc` directly and go to LOOKUP; otherwise go to IDLE. `ready_o` = `next_ready` in OUT.
- LRU: one bit per set, meaning "next victim way". Absent when WAYS=1.
- Flush: `flush_i` clears every valid bit at the next edge, in any state.
  - During FILL the refill completes and delivers the instruction, but the line is NOT marked valid if flush occurred at any point during that fill (a sticky bit cleared on entering REQ).
  - Flush in the same cycle as a LOOKUP hit: the hit is honoured and the clear applies afterwards.

## Timing
- Reset (async) values: state IDLE; `valid_o`=0, `ready_o`=1, `ifu_arvalid_o`=0, `ifu_araddr_o`=0, `inst_o`=0, `pc_o`=0; all valid bits 0; all LRU bits 0; beat counter 0. `ifu_arlen_o` is constant.
- Hit latency: request accepted at cycle N, `valid_o` high at N+2 (one cycle in LOOKUP).
- Miss latency: N+2 `arvalid`; after `arready` at cycle A, the last beat at cycle B gives `valid_o` at B+1.
- Back-to-back hits: one instruction every 2 cycles while `next_ready`=1.
- `valid_o`, `inst_o`, `pc_o` stay stable until `next_ready`.
- Upstream inputs are ignored whenever `ready_o`=0.
- Reset mid-burst: the block returns to IDLE immediately. The bus side must drop the outstanding burst; remaining beats arriving in IDLE are ignored.

## Configuration
- `YSYX_L1I_EN` defined: cache as above.
- Not defined: no tag/data/valid/LRU storage. Every request goes IDLE→REQ (skipping LOOKUP) with `ifu_araddr_o` = word-aligned `pc` and `ifu_arlen_o`=0. The single beat loads `inst_o` and goes to OUT. `flush_i` is ignored. Ports are unchanged.

## Test plan
- Cold fetch at 0x8000_0000, LINE_WORDS=4 → one burst: araddr 0x8000_0000, arlen 3, 4 beats; `inst_o` = beat 0, `valid_o` 1 cycle after beat 3.
- Fetch 0x8000_0008 next → hit, no `arvalid`; `inst_o` = beat 2, `valid_o` 2 cycles after handshake.
- WAYS=2, SETS=16, line 16 B: fetch 0x8000_0000, 0x8000_0100, 0x8000_0000, then 0x8000_0200 → third access hits; fourth evicts the 0x100 line, so re-fetching 0x8000_0100 misses.
- `flush_i` pulse, then fetch 0x8000_0000 → miss with a full burst. Flush during beat 1 of a fill → instruction delivered, next fetch of the same line misses.
- Hold `next_ready`=0 for 5 cycles in OUT → `valid_o`, `inst_o`, `pc_o` constant and `ready_o`=0; with `prev_valid` and `next_ready` both high in the same cycle, the new request enters LOOKUP without passing through IDLE.
- Assert `rst` in FILL after 2 beats → all outputs at reset values immediately. A subsequent fetch of the same address misses (the line was never validated).

Source files
------------

// File: rtl/ysyx_l1i_fetch.sv
// Instruction-fetch stage with a set-associative L1 I-cache refilled by one burst per line.
// Build with YSYX_L1I_EN defined for the cache; without it every fetch is a single-beat bus read.
module ysyx_l1i_fetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prev_valid,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              next_ready,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] ifu_araddr_o,
    output logic [7:0]        ifu_arlen_o,
    output logic              ifu_arvalid_o,
    input  logic              ifu_arready,
    input  logic [DATA_W-1:0] ifu_rdata,
    input  logic              ifu_rvalid,
    input  logic              ifu_rlast
);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_REQ    = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] pc_al;
    logic              accept;

    // Handshakes: a transfer happens on a rising edge where both valid and ready are high.
    assign ready_o       = (state == S_IDLE) || ((state == S_OUT) && next_ready);
    assign valid_o       = (state == S_OUT);
    assign ifu_arvalid_o = (state == S_REQ);
    assign accept        = prev_valid && ready_o;
    assign pc_al         = {pc[ADDR_W-1:2], 2'b00};

`ifdef YSYX_L1I_EN
    assign ifu_arlen_o = 8'(LINE_WORDS - 1);

    logic [DATA_W-1:0] data_mem [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [SETS-1:0]   valid_q  [WAYS];
    logic [SETS-1:0]   lru_q;
    logic              flush_seen;
    logic              victim_q;
    logic [WSEL_W-1:0] beat_cnt;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic [ADDR_W-1:0] line_addr;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              last_beat;
    logic [DATA_W-1:0] hit_word;

    assign idx       = req_addr[OFF_W +: IDX_W];
    assign tag       = req_addr[ADDR_W-1 -: TAG_W];
    assign word_sel  = req_addr[2 +: WSEL_W] & WSEL_W'(LINE_WORDS - 1);
    assign line_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign last_beat = ifu_rvalid && (beat_cnt == WSEL_W'(LINE_WORDS - 1));
    assign hit_word  = data_mem[hit_way][idx][word_sel];

    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_mem[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Invalid way0 first, then invalid way1, otherwise the way the LRU bit names.
    always_comb begin
        victim = 1'b0;
        if (WAYS > 1) begin
            if (!valid_q[0][idx])
                victim = 1'b0;
            else if (!valid_q[WAYS-1][idx])
                victim = 1'b1;
            else
                victim = lru_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_FILL) && ifu_rvalid)
            data_mem[victim_q][idx][beat_cnt] <= ifu_rdata;
        if ((state == S_FILL) && last_beat)
            tag_mem[victim_q][idx] <= tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= '0;
        else if (state == S_REQ)
            beat_cnt <= '0;
        else if ((state == S_FILL) && ifu_rvalid)
            beat_cnt <= beat_cnt + 1'b1;
    end

    // The victim is invalidated as soon as it is chosen so a half-written line is never hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                valid_q[w] <= '0;
            lru_q      <= '0;
            flush_seen <= 1'b0;
            victim_q   <= 1'b0;
        end else begin
            if ((state == S_LOOKUP) && !hit) begin
                victim_q   <= victim;
                flush_seen <= 1'b0;
            end else if (((state == S_REQ) || (state == S_FILL)) && flush_i) begin
                flush_seen <= 1'b1;
            end

            if (flush_i) begin
                for (int w = 0; w < WAYS; w++)
                    valid_q[w] <= '0;
            end else if ((state == S_LOOKUP) && !hit) begin
                valid_q[victim][idx] <= 1'b0;
            end else if ((state == S_FILL) && last_beat && !flush_seen) begin
                valid_q[victim_q][idx] <= 1'b1;
            end

            if (WAYS > 1) begin
                if ((state == S_LOOKUP) && hit)
                    lru_q[idx] <= ~hit_way;
                else if ((state == S_FILL) && last_beat)
                    lru_q[idx] <= ~victim_q;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{ifu_rlast, pc[1:0]};
`else
    assign ifu_arlen_o = 8'd0;

    logic unused_ok;
    assign unused_ok = ^{ifu_rlast, pc[1:0], flush_i};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            req_addr     <= '0;
            ifu_araddr_o <= '0;
            inst_o       <= '0;
            pc_o         <= '0;
        end else begin
            case (state)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        req_addr <= pc_al;
`ifdef YSYX_L1I_EN
                        state    <= S_LOOKUP;
`else
                        ifu_araddr_o <= pc_al;
                        state        <= S_REQ;
`endif
                    end else if ((state == S_OUT) && next_ready) begin
                        state <= S_IDLE;
                    end
                end
`ifdef YSYX_L1I_EN
                S_LOOKUP: begin
                    if (hit) begin
                        inst_o <= hit_word;
                        pc_o   <= req_addr;
                        state  <= S_OUT;
                    end else begin
                        ifu_araddr_o <= line_addr;
                        state        <= S_REQ;
                    end
                end
`endif
                S_REQ: begin
                    if (ifu_arready)
                        state <= S_FILL;
                end
                S_FILL: begin
`ifdef YSYX_L1I_EN
                    if (ifu_rvalid) begin
                        if (beat_cnt == word_sel)
                            inst_o <= ifu_rdata;
                        if (last_beat) begin
                            pc_o  <= req_addr;
                            state <= S_OUT;
                        end
                    end
`else
                    if (ifu_rvalid) begin
                        inst_o <= ifu_rdata;
                        pc_o   <= req_addr;
                        state  <= S_OUT;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
